// File: rtl/add_sub_arbiter_pkg.sv
// rtl/add_sub_arbiter_pkg.sv - shared types and opcode encodings for add_sub_arbiter
package add_sub_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_sub.sv
// rtl/add_sub.sv - shared WIDTH-bit adder/subtractor with carry/borrow out
module add_sub
    import add_sub_arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sign,
    output logic [WIDTH-1:0] z,
    output logic             carry
);

    logic [WIDTH:0] full;

    // Zero-extended add or subtract; the top bit is the carry (add) or borrow (sub)
    always_comb begin
        full = '0;
        if (sign == OP_SUB) begin
            full = {1'b0, x} - {1'b0, y};
        end else begin
            full = {1'b0, x} + {1'b0, y};
        end
    end

    assign z     = full[WIDTH-1:0];
    assign carry = full[WIDTH];

endmodule

// File: rtl/add_sub_arbiter_rr_arbiter.sv
// rtl/add_sub_arbiter_rr_arbiter.sv - combinational round-robin request picker
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_valid
);

    logic [IDW-1:0] cand;

    // (ptr + k) mod NREQ without a divider; result always < NREQ
    function automatic int wrap_idx(input int p, input int k);
        int s;
        s = p + k;
        if (s >= NREQ) s = s - NREQ;
        return s;
    endfunction

    // Scan from the farthest candidate back to ptr so the closest valid one wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'(wrap_idx(int'(ptr), k));
            if (req[cand]) begin
                grant_idx = cand;
                any_valid = 1'b1;
            end
        end
        if (any_valid) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/add_sub_arbiter.sv
// rtl/add_sub_arbiter.sv - round-robin sharing of one add_sub among NREQ requesters (option: ADD_SUB_ARBITER_CARRY_EN)
module add_sub_arbiter
    import add_sub_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    input  logic [NREQ-1:0]       req_sign,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_z,
    output logic                  busy
`ifdef ADD_SUB_ARBITER_CARRY_EN
    ,
    output logic                  rsp_carry
`endif
);

    localparam int IDW = $clog2(NREQ);

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_q;
    logic [WIDTH-1:0] x_q, y_q;
    logic             sign_q;
    logic [NREQ-1:0]  arb_grant;
    logic [IDW-1:0]   arb_idx;
    logic             arb_any;
    logic             accept;
    logic             rsp_done;
    logic [WIDTH-1:0] sum_z;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_valid (arb_any)
    );

`ifdef ADD_SUB_ARBITER_CARRY_EN
    logic sum_c;

    add_sub #(.WIDTH(WIDTH)) u_add_sub (
        .x     (x_q),
        .y     (y_q),
        .sign  (sign_q),
        .z     (sum_z),
        .carry (sum_c)
    );
`else
    add_sub #(.WIDTH(WIDTH)) u_add_sub (
        .x     (x_q),
        .y     (y_q),
        .sign  (sign_q),
        .z     (sum_z),
        .carry ()
    );
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs; ready only in IDLE, so no accept while a response is pending
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        accept    = 1'b0;
        rsp_done  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (arb_any) begin
                    req_ready = arb_grant;
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, result register and round-robin pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            gnt_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            sign_q <= OP_ADD;
            rsp_z  <= '0;
`ifdef ADD_SUB_ARBITER_CARRY_EN
            rsp_carry <= 1'b0;
`endif
        end else begin
            if (accept) begin
                gnt_q  <= arb_idx;
                x_q    <= req_x[arb_idx*WIDTH +: WIDTH];
                y_q    <= req_y[arb_idx*WIDTH +: WIDTH];
                sign_q <= req_sign[arb_idx];
            end
            if (state == EXEC) begin
                rsp_z <= sum_z;
`ifdef ADD_SUB_ARBITER_CARRY_EN
                rsp_carry <= sum_c;
`endif
            end
            if (rsp_done) begin
                rr_ptr <= (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
            end
        end
    end

endmodule

// File: doc/add_sub_arbiter.md
Name: add_sub_arbiter

Overview:
- Shares one `add_sub` datapath instance among NREQ requesters.
- Round-robin arbitration, per-requester valid/ready request and response handshakes, and one operation in flight at a time.
- Sits between requester blocks (e.g. `alu` instances, sequencers) and the single shared adder/subtractor.

Parameters:
- WIDTH, 32: operand/result width passed to the `add_sub` instance.
- NREQ, 4: number of requesters, legal range 2..8.
- IDW, $clog2(NREQ): width of the internal grant index (localparam, not overridable).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  requester i has an operation pending.
- req_ready  output  NREQ  one-hot or zero; requester i's operation accepted this cycle when valid&ready.
- req_x  input  NREQ*WIDTH  operand x, requester i at [i*WIDTH +: WIDTH].
- req_y  input  NREQ*WIDTH  operand y, same packing.
- req_sign  input  NREQ  0 = add, 1 = subtract.
- rsp_valid  output  NREQ  one-hot or zero; result available for requester i.
- rsp_ready  input  NREQ  requester i consumes result.
- rsp_z  output  WIDTH  shared result bus, meaningful only while some rsp_valid bit is high.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_z=0, busy=0.
  - Operand/grant registers cleared.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[grant]=1 only if some request is valid; combinational from req_valid and rr_ptr.
  - On handshake: latch x, y, sign and grant index, then go to EXEC.
  - No valid request: stay in IDLE, req_ready=0.
- EXEC:
  - Latched operands drive `add_sub`.
  - z = sign ? x-y : x+y, modulo 2^WIDTH; overflow bits are discarded.
  - Result is registered into rsp_z at the end of the cycle; go to RESP.
- RESP:
  - rsp_valid[grant]=1 and rsp_z held stable until rsp_ready[grant].
  - On handshake: rr_ptr = (grant+1) mod NREQ, go to IDLE.
  - rsp_ready on non-granted bits is ignored.
- Latency: request accepted in cycle N, rsp_valid high in cycle N+2. If rsp_ready is high in N+2, the next acceptance is in N+3. Peak throughput is one operation per 3 cycles.
- req_ready is 0 in EXEC and RESP. A new request is never accepted while a response is outstanding, including in the cycle rsp_ready is asserted.
- Fairness: a continuously valid requester is granted within NREQ grants.
- A requester dropping req_valid without a handshake is legal and never granted. Dropping req_valid after acceptance has no effect.
- Operands on req_x/req_y may change freely after acceptance.
- Reset asserted mid-operation: in-flight operation is discarded, no response is issued, rr_ptr returns to 0.
- rr_ptr wraps from NREQ-1 to 0. Non-power-of-two NREQ must not grant indices >= NREQ.

Optional Feature:
- Macro: ADD_SUB_ARBITER_CARRY_EN.
- Defined:
  - Extra output rsp_carry (1 bit), registered alongside rsp_z with the same timing.
  - For add it is the carry out of x+y (bit WIDTH of the zero-extended sum).
  - For subtract it is the borrow, 1 iff x<y unsigned.
  - The `add_sub` carry port is connected.
  - Reset value 0.
- Undefined: port absent, `add_sub` carry port left unconnected, no extra flops.

Decomposition:
- Package add_sub_arb_pkg holds:
  - typedef enum of state_t {IDLE, EXEC, RESP} (2 bits).
  - Encodings OP_ADD=1'b0 and OP_SUB=1'b1.
- Sub-module rr_arbiter (parameter NREQ): inputs req vector and ptr; outputs one-hot grant, grant index and any_valid. Purely combinational, reused for future shared resources.
- Top level holds FSM, operand/result registers, rr_ptr and one `add_sub` #(WIDTH) instance.

Test Plan:
- Single requester: req 1 valid, x=5, y=7, sign=0, rsp_ready=1. Expect accept at cycle 0, rsp_valid=4'b0010 with rsp_z=12 at cycle 2, busy high for cycles 1-2.
- Subtract wrap: x=3, y=5, sign=1. Expect rsp_z=32'hFFFF_FFFE; with CARRY_EN, rsp_carry=1. Add x=32'hFFFF_FFFF, y=1: expect rsp_z=0, rsp_carry=1.
- Round-robin: all 4 requesters valid continuously with distinct operands. Expect grant order 0,1,2,3,0 and each rsp_z matching its own operands.
- Response backpressure: rsp_ready held 0 for 5 cycles with requester 2 waiting. Expect rsp_valid and rsp_z stable and req_ready=0 throughout; requester 2 is granted the cycle after the rsp handshake.
- Reset mid-flight: assert rst_n=0 in EXEC. Expect all outputs 0 immediately with no rsp_valid after release; the next grant starts scanning from index 0.
- NREQ=3 build: valid on 2 and 0 with rr_ptr=2. Expect grant 2 then 0; never index 3.
